// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-clock storage array for an asynchronous FIFO, registered or combinational read.
// Define FIFO_MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on PAR_ERR.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int READ_REG   = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  W_CLKEN,
  input  logic                  W_FULL,
  input  logic [ADDR_WIDTH-1:0] W_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  W_OVF,
  input  logic                  R_CLKEN,
  input  logic                  R_EMPTY,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  R_UDF,
  output logic                  PAR_ERR
);

`ifdef FIFO_MEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  function automatic logic even_par(input logic [DATA_WIDTH-1:0] d);
    even_par = ^d;
  endfunction

  logic [MEM_W-1:0]      r_mem [DEPTH];
  logic                  r_w_ovf;
  logic                  r_r_udf;
  logic [MEM_W-1:0]      w_wr_word;
  logic [MEM_W-1:0]      w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_par_err;
  logic                  w_rd_req;

`ifdef FIFO_MEM_PARITY_EN
  assign w_wr_word = {even_par(WR_DATA), WR_DATA};
  assign w_par_err = (w_rd_word[MEM_W-1] != even_par(w_rd_data));
`else
  assign w_wr_word = WR_DATA;
  assign w_par_err = 1'b0;
`endif

  assign w_rd_word = r_mem[R_ADDR];
  assign w_rd_data = w_rd_word[DATA_WIDTH-1:0];
  assign w_rd_req  = R_CLKEN && !R_EMPTY;

  // Write port: all-zero words after reset also carry correct (zero) parity.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_w_ovf <= 1'b0;
    end else begin
      if (W_CLKEN && !W_FULL) begin
        r_mem[W_ADDR] <= w_wr_word;
      end
      if (W_CLKEN && W_FULL) begin
        r_w_ovf <= 1'b1;
      end
    end
  end

  // Sticky underflow flag in the read domain.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_r_udf <= 1'b0;
    end else if (R_CLKEN && R_EMPTY) begin
      r_r_udf <= 1'b1;
    end
  end

  assign W_OVF = r_w_ovf;
  assign R_UDF = r_r_udf;

  if (READ_REG != 0) begin : g_rd_reg
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_par_err;

    // Registered read port; data holds when no read is accepted.
    always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
        r_par_err  <= 1'b0;
      end else if (w_rd_req) begin
        r_rd_data  <= w_rd_data;
        r_rd_valid <= 1'b1;
        r_par_err  <= w_par_err;
      end else begin
        r_rd_valid <= 1'b0;
        r_par_err  <= 1'b0;
      end
    end

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign PAR_ERR  = r_par_err;
  end else begin : g_rd_comb
    // Read-domain reset still forces the outputs to their reset values.
    assign RD_DATA  = R_RST ? w_rd_data : '0;
    assign RD_VALID = R_RST && w_rd_req;
    assign PAR_ERR  = R_RST && w_rd_req && w_par_err;
  end

endmodule

// File: tb/tb_fifo_mem_dp.sv
// tb_fifo_mem_dp: directed bench for fifo_mem_dp, one registered-read (DEPTH 8)
// and one combinational-read (DEPTH 16) instance sharing the two clocks.
module tb_fifo_mem_dp;
  logic w_clk = 1'b0;
  logic r_clk = 1'b0;
  always #5 w_clk = ~w_clk;
  always #7 r_clk = ~r_clk;

  int n_pass = 0;
  int n_total = 0;

  // Registered-read instance
  logic       w_rst, r_rst, w_clken, w_full, r_clken, r_empty;
  logic [2:0] w_addr, r_addr;
  logic [7:0] wr_data, rd_data;
  logic       w_ovf, rd_valid, r_udf, par_err;

  // Combinational-read instance
  logic       c_w_rst, c_r_rst, c_w_clken, c_w_full, c_r_clken, c_r_empty;
  logic [3:0] c_w_addr, c_r_addr;
  logic [7:0] c_wr_data, c_rd_data;
  logic       c_w_ovf, c_rd_valid, c_r_udf, c_par_err;

  fifo_mem_dp #(.DATA_WIDTH(8), .DEPTH(8), .READ_REG(1)) dut (
    .W_CLK(w_clk), .W_RST(w_rst), .R_CLK(r_clk), .R_RST(r_rst),
    .W_CLKEN(w_clken), .W_FULL(w_full), .W_ADDR(w_addr), .WR_DATA(wr_data),
    .W_OVF(w_ovf), .R_CLKEN(r_clken), .R_EMPTY(r_empty), .R_ADDR(r_addr),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .R_UDF(r_udf), .PAR_ERR(par_err)
  );

  fifo_mem_dp #(.DATA_WIDTH(8), .DEPTH(16), .READ_REG(0)) dut_c (
    .W_CLK(w_clk), .W_RST(c_w_rst), .R_CLK(r_clk), .R_RST(c_r_rst),
    .W_CLKEN(c_w_clken), .W_FULL(c_w_full), .W_ADDR(c_w_addr), .WR_DATA(c_wr_data),
    .W_OVF(c_w_ovf), .R_CLKEN(c_r_clken), .R_EMPTY(c_r_empty), .R_ADDR(c_r_addr),
    .RD_DATA(c_rd_data), .RD_VALID(c_rd_valid), .R_UDF(c_r_udf), .PAR_ERR(c_par_err)
  );

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d, input logic full);
    @(negedge w_clk);
    w_clken = 1'b1; w_addr = a; wr_data = d; w_full = full;
    @(posedge w_clk); #1;
    w_clken = 1'b0; w_full = 1'b0;
  endtask

  task automatic write_comb(input logic [3:0] a, input logic [7:0] d);
    @(negedge w_clk);
    c_w_clken = 1'b1; c_w_addr = a; c_wr_data = d;
    @(posedge w_clk); #1;
    c_w_clken = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a);
    @(negedge r_clk);
    r_clken = 1'b1; r_empty = 1'b0; r_addr = a;
    @(posedge r_clk); #1;
    r_clken = 1'b0;
  endtask

  task automatic test_reset();
    w_rst = 1'b0; r_rst = 1'b0; c_w_rst = 1'b0; c_r_rst = 1'b0;
    w_clken = 1'b0; w_full = 1'b0; w_addr = 3'd0; wr_data = 8'h00;
    r_clken = 1'b0; r_empty = 1'b0; r_addr = 3'd0;
    c_w_clken = 1'b0; c_w_full = 1'b0; c_w_addr = 4'd0; c_wr_data = 8'h00;
    c_r_clken = 1'b0; c_r_empty = 1'b0; c_r_addr = 4'd0;
    #3;
    n_total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else n_pass++;
    n_total++; if (w_ovf !== 1'b0) $display("FAIL reset_w_ovf: got %b expected 0", w_ovf); else n_pass++;
    n_total++; if (r_udf !== 1'b0) $display("FAIL reset_r_udf: got %b expected 0", r_udf); else n_pass++;
    n_total++; if (par_err !== 1'b0) $display("FAIL reset_par_err: got %b expected 0", par_err); else n_pass++;
    n_total++; if (c_rd_data !== 8'h00) $display("FAIL reset_comb_rd_data: got %h expected 00", c_rd_data); else n_pass++;
    #20;
    w_rst = 1'b1; r_rst = 1'b1; c_w_rst = 1'b1; c_r_rst = 1'b1;
    repeat (2) @(posedge r_clk);
    #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = 8'(8'h11 * (i + 1));
      write_reg(3'(i), exp, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge r_clk);
      r_clken = 1'b1; r_empty = 1'b0; r_addr = 3'(i);
      if (i == 0) begin
        #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL drain_latency: valid %b before edge, expected 0", rd_valid); else n_pass++;
      end
      @(posedge r_clk); #1;
      exp = 8'(8'h11 * (i + 1));
      n_total++; if (rd_data !== exp) $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data, exp); else n_pass++;
      n_total++; if (rd_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b expected 1", i, rd_valid); else n_pass++;
      n_total++; if (par_err !== 1'b0) $display("FAIL drain_par_err[%0d]: got %b expected 0", i, par_err); else n_pass++;
    end
    @(negedge r_clk);
    r_clken = 1'b0;
    @(posedge r_clk); #1;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL drain_idle_valid: got %b expected 0", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 8'h88) $display("FAIL drain_idle_hold: got %h expected 88", rd_data); else n_pass++;
  endtask

  task automatic test_overflow();
    write_reg(3'd3, 8'hAA, 1'b1);
    n_total++; if (w_ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", w_ovf); else n_pass++;
    read_reg(3'd3);
    n_total++; if (rd_data !== 8'h44) $display("FAIL ovf_mem_kept: got %h expected 44", rd_data); else n_pass++;
    write_reg(3'd7, 8'h88, 1'b0);
    n_total++; if (w_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", w_ovf); else n_pass++;
  endtask

  task automatic test_underflow();
    @(negedge r_clk);
    r_clken = 1'b1; r_empty = 1'b1; r_addr = 3'd5;
    @(posedge r_clk); #1;
    r_clken = 1'b0; r_empty = 1'b0;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL udf_valid: got %b expected 0", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 8'h44) $display("FAIL udf_data_hold: got %h expected 44", rd_data); else n_pass++;
    n_total++; if (r_udf !== 1'b1) $display("FAIL udf_set: got %b expected 1", r_udf); else n_pass++;
    repeat (2) @(posedge r_clk);
    #1;
    n_total++; if (r_udf !== 1'b1) $display("FAIL udf_sticky: got %b expected 1", r_udf); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    write_comb(4'd15, 8'h5A);
    write_comb(4'd0, 8'hA5);
    c_r_clken = 1'b1; c_r_empty = 1'b0; c_r_addr = 4'd15;
    #1;
    n_total++; if (c_rd_data !== 8'h5A) $display("FAIL wrap_addr15: got %h expected 5a", c_rd_data); else n_pass++;
    n_total++; if (c_rd_valid !== 1'b1) $display("FAIL comb_valid: got %b expected 1", c_rd_valid); else n_pass++;
    c_r_addr = 4'd0;
    #1;
    n_total++; if (c_rd_data !== 8'hA5) $display("FAIL wrap_addr0: got %h expected a5", c_rd_data); else n_pass++;
    c_r_empty = 1'b1;
    #1;
    n_total++; if (c_rd_valid !== 1'b0) $display("FAIL comb_valid_empty: got %b expected 0", c_rd_valid); else n_pass++;
    @(posedge r_clk); #1;
    c_r_clken = 1'b0; c_r_empty = 1'b0;
    n_total++; if (c_r_udf !== 1'b1) $display("FAIL comb_udf: got %b expected 1", c_r_udf); else n_pass++;
    @(negedge w_clk);
    c_w_rst = 1'b0;
    #2;
    c_w_rst = 1'b1;
    c_r_addr = 4'd15;
    #1;
    n_total++; if (c_rd_data !== 8'h00) $display("FAIL wrst_addr15: got %h expected 00", c_rd_data); else n_pass++;
    c_r_addr = 4'd0;
    #1;
    n_total++; if (c_rd_data !== 8'h00) $display("FAIL wrst_addr0: got %h expected 00", c_rd_data); else n_pass++;
    n_total++; if (c_r_udf !== 1'b1) $display("FAIL wrst_keeps_udf: got %b expected 1", c_r_udf); else n_pass++;
  endtask

  task automatic test_indep_reset();
    @(negedge r_clk);
    r_clken = 1'b1; r_empty = 1'b0; r_addr = 3'd6;
    @(posedge r_clk); #1;
    n_total++; if (rd_data !== 8'h77) $display("FAIL stream_data: got %h expected 77", rd_data); else n_pass++;
    #2;
    r_rst = 1'b0;
    #1;
    n_total++; if (rd_data !== 8'h00) $display("FAIL rrst_data: got %h expected 00", rd_data); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL rrst_valid: got %b expected 0", rd_valid); else n_pass++;
    n_total++; if (r_udf !== 1'b0) $display("FAIL rrst_udf: got %b expected 0", r_udf); else n_pass++;
    n_total++; if (w_ovf !== 1'b1) $display("FAIL rrst_keeps_ovf: got %b expected 1", w_ovf); else n_pass++;
    @(negedge r_clk);
    r_rst = 1'b1; r_addr = 3'd5;
    @(posedge r_clk); #1;
    r_clken = 1'b0;
    n_total++; if (rd_data !== 8'h66) $display("FAIL rrst_mem_kept: got %h expected 66", rd_data); else n_pass++;
    n_total++; if (rd_valid !== 1'b1) $display("FAIL rrst_first_read_valid: got %b expected 1", rd_valid); else n_pass++;
  endtask

  task automatic test_write_reset();
    @(negedge w_clk);
    w_rst = 1'b0;
    #2;
    n_total++; if (w_ovf !== 1'b0) $display("FAIL wrst_ovf: got %b expected 0", w_ovf); else n_pass++;
    w_rst = 1'b1;
    read_reg(3'd3);
    n_total++; if (rd_data !== 8'h00) $display("FAIL wrst_mem_clear: got %h expected 00", rd_data); else n_pass++;
    n_total++; if (rd_valid !== 1'b1) $display("FAIL wrst_read_valid: got %b expected 1", rd_valid); else n_pass++;
  endtask

`ifdef FIFO_MEM_PARITY_EN
  task automatic test_parity();
    write_reg(3'd1, 8'h44, 1'b0);
    write_reg(3'd2, 8'h33, 1'b0);
    dut.r_mem[2] = dut.r_mem[2] ^ 9'h001;
    read_reg(3'd2);
    n_total++; if (par_err !== 1'b1) $display("FAIL parity_flip: got %b expected 1", par_err); else n_pass++;
    n_total++; if (rd_valid !== 1'b1) $display("FAIL parity_flip_valid: got %b expected 1", rd_valid); else n_pass++;
    read_reg(3'd1);
    n_total++; if (par_err !== 1'b0) $display("FAIL parity_clean: got %b expected 0", par_err); else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap_reset();
    test_indep_reset();
    test_write_reset();
`ifdef FIFO_MEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
